conv_channel_accum_post: RTL and testbench

Downstream consumer of the 49-input pipelined adder tree (7×7 window sum, Q22.16). Accumulates successive window sums across input channels of one output pixel, then adds a Q16.16 bias, applies optional ReLU and saturates back to Q16.16 for the next layer. The block has a two-stage pipeline: accumulate, then bias/ReLU/saturate. It accepts back-to-back channel groups with no bubble.

---
 rtl/conv_channel_accum_post.sv | 137 +++++++++++++
 tb/tb_conv_channel_accum_post.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/conv_channel_accum_post.sv
// conv_channel_accum_post: accumulates per-channel 7x7 window sums of one
// output pixel, then adds bias, applies optional ReLU and saturates to Q16.16.
// Stage A accumulates a group of channel beats; stage B post-processes the
// finished sum while stage A is already loading the next group.
module conv_channel_accum_post #(
    parameter int IN_W  = 38,
    parameter int OUT_W = 32,
    parameter int CH_W  = 7,
    parameter int ACC_W = 44
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_sum,
    input  logic [CH_W-1:0]         cfg_num_ch,
    input  logic signed [OUT_W-1:0] bias,
    input  logic                    relu_en,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat,
    output logic                    busy
);

    localparam logic [CH_W-1:0] ONE_CH = {{(CH_W-1){1'b0}}, 1'b1};
    localparam int HI_W = ACC_W - OUT_W + 2;

    // Stage A state
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CH_W-1:0]         cnt_q, cnt_d;
    logic [CH_W-1:0]         n_q, n_d;
    logic                    done_q, done_d;
    logic signed [OUT_W-1:0] bias_q, bias_d;
    logic                    relu_q, relu_d;

    // Stage B state
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;

    // Helpers
    logic                    beat;
    logic                    last_beat;
    logic [CH_W-1:0]         n_cfg;
    logic [CH_W-1:0]         n_use;
    logic signed [ACC_W-1:0] sum_ext;
    logic signed [ACC_W:0]   s_full;
    logic signed [ACC_W:0]   s_relu;
    logic [HI_W-1:0]         s_hi;

    // Stage A: first beat loads, later beats add; the final beat flags done and captures post settings
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        done_d    = done_q;
        bias_d    = bias_q;
        relu_d    = relu_q;
        beat      = en & in_valid;
        n_cfg     = (cfg_num_ch == '0) ? ONE_CH : cfg_num_ch;
        n_use     = (cnt_q == '0) ? n_cfg : n_q;
        last_beat = (cnt_q == (n_use - ONE_CH));
        sum_ext   = {{(ACC_W-IN_W){in_sum[IN_W-1]}}, in_sum};
        if (beat) begin
            acc_d = (cnt_q == '0) ? sum_ext : (acc_q + sum_ext);
            n_d   = n_use;
            if (last_beat) begin
                cnt_d  = '0;
                done_d = 1'b1;
                bias_d = bias;
                relu_d = relu_en;
            end else begin
                cnt_d  = cnt_q + ONE_CH;
                done_d = 1'b0;
            end
        end else if (en) begin
            done_d = 1'b0;
        end
    end

    // Stage B: bias add, optional ReLU, and clip the wide sum back into Q16.16
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        s_full      = {acc_q[ACC_W-1], acc_q}
                    + {{(ACC_W+1-OUT_W){bias_q[OUT_W-1]}}, bias_q};
        s_relu      = (relu_q && s_full[ACC_W]) ? '0 : s_full;
        s_hi        = s_relu[ACC_W:OUT_W-1];
        if (en) begin
            out_valid_d = done_q;
            if (done_q) begin
                if ((s_hi == '0) || (s_hi == '1)) begin
                    out_data_d = s_relu[OUT_W-1:0];
                    out_sat_d  = 1'b0;
                end else if (!s_relu[ACC_W]) begin
                    out_data_d = {1'b0, {(OUT_W-1){1'b1}}};
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = {1'b1, {(OUT_W-1){1'b0}}};
                    out_sat_d  = 1'b1;
                end
            end
        end
    end

    // Register update with synchronous active-low reset that discards any partial group
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            n_q         <= ONE_CH;
            done_q      <= 1'b0;
            bias_q      <= '0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            done_q      <= done_d;
            bias_q      <= bias_d;
            relu_q      <= relu_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_conv_channel_accum_post.sv
// Testbench for conv_channel_accum_post: directed channel groups, expected
// results queued at issue time and popped by an independent output monitor.
module tb_conv_channel_accum_post;

    typedef struct packed {
        logic [31:0] data;
        logic        sat;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               en;
    logic               in_valid;
    logic signed [37:0] in_sum;
    logic [6:0]         cfg_num_ch;
    logic signed [31:0] bias;
    logic               relu_en;
    logic               out_valid;
    logic signed [31:0] out_data;
    logic               out_sat;
    logic               busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    conv_channel_accum_post dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_sum     (in_sum),
        .cfg_num_ch (cfg_num_ch),
        .bias       (bias),
        .relu_en    (relu_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .busy       (busy)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value and tally the result
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs from just after a falling edge, then advance to the next falling edge
    task automatic applyStimulus(input logic signed [37:0] sum, input logic [6:0] cfg,
                                 input logic signed [31:0] b, input logic r,
                                 input logic en_v, input logic valid_v);
        in_sum     = sum;
        cfg_num_ch = cfg;
        bias       = b;
        relu_en    = r;
        en         = en_v;
        in_valid   = valid_v;
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus('0, 7'd1, 32'sd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic expectResult(input logic [31:0] data, input logic sat);
        exp_t e;
        e.data = data;
        e.sat  = sat;
        exp_q.push_back(e);
    endtask

    // Monitor: each fresh out_valid (after an enabled, non-reset edge) consumes one expected result
    initial begin
        logic en_s;
        logic rst_s;
        exp_t e;
        forever begin
            @(posedge clk);
            en_s  = en;
            rst_s = rst;
            #1;
            if (en_s && rst_s && out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("out_sat", {31'd0, out_sat}, {31'd0, e.sat});
                end
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence
    initial begin
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_sum = '0;
        cfg_num_ch = 7'd1; bias = '0; relu_en = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkOutput("reset_out_sat", {31'd0, out_sat}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        idle(2);

        $display("[TB] three-channel group, 49.0 + 24.5 + 1.5");
        applyStimulus(38'sd3211264, 7'd3, 32'sd0, 1'b0, 1'b1, 1'b1);
        checkOutput("busy_after_b1", {31'd0, busy}, 32'd1);
        applyStimulus(38'sd1605632, 7'd3, 32'sd0, 1'b0, 1'b1, 1'b1);
        checkOutput("busy_after_b2", {31'd0, busy}, 32'd1);
        expectResult(32'h004B0000, 1'b0);
        applyStimulus(38'sd98304, 7'd3, 32'sd0, 1'b0, 1'b1, 1'b1);
        checkOutput("busy_after_b3", {31'd0, busy}, 32'd0);
        idle(3);

        $display("[TB] single channel, -2.0 + 0.5 with and without ReLU");
        expectResult(32'h00000000, 1'b0);
        applyStimulus(-38'sd131072, 7'd1, 32'sd32768, 1'b1, 1'b1, 1'b1);
        checkOutput("busy_n1", {31'd0, busy}, 32'd0);
        idle(2);
        expectResult(32'hFFFE8000, 1'b0);
        applyStimulus(-38'sd131072, 7'd0, 32'sd32768, 1'b0, 1'b1, 1'b1);
        idle(2);

        $display("[TB] saturation both directions");
        applyStimulus(38'sh10_0000_0000, 7'd2, 32'sd0, 1'b0, 1'b1, 1'b1);
        expectResult(32'h7FFFFFFF, 1'b1);
        applyStimulus(38'sh10_0000_0000, 7'd2, 32'sd0, 1'b0, 1'b1, 1'b1);
        idle(2);
        applyStimulus(-38'sh10_0000_0000, 7'd2, 32'sd0, 1'b0, 1'b1, 1'b1);
        expectResult(32'h80000000, 1'b1);
        applyStimulus(-38'sh10_0000_0000, 7'd2, 32'sd0, 1'b0, 1'b1, 1'b1);
        idle(2);

        $display("[TB] stall with en low and in_valid high");
        applyStimulus(38'sd3211264, 7'd3, 32'sd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(38'sd1605632, 7'd3, 32'sd0, 1'b0, 1'b0, 1'b1);
            checkOutput("busy_stall", {31'd0, busy}, 32'd1);
        end
        applyStimulus(38'sd1605632, 7'd3, 32'sd0, 1'b0, 1'b1, 1'b1);
        expectResult(32'h004B0000, 1'b0);
        applyStimulus(38'sd98304, 7'd3, 32'sd0, 1'b0, 1'b1, 1'b1);
        idle(3);

        $display("[TB] back-to-back groups of two");
        expectResult(32'h00030000, 1'b0);
        expectResult(32'h00070000, 1'b0);
        applyStimulus(38'sd65536, 7'd2, 32'sd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(38'sd131072, 7'd2, 32'sd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(38'sd196608, 7'd2, 32'sd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(38'sd262144, 7'd2, 32'sd0, 1'b0, 1'b1, 1'b1);
        idle(3);

        $display("[TB] reset in the middle of a group");
        applyStimulus(38'sd327680, 7'd3, 32'sd0, 1'b0, 1'b1, 1'b1);
        checkOutput("busy_before_reset", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        applyStimulus('0, 7'd3, 32'sd0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        checkOutput("busy_after_reset", {31'd0, busy}, 32'd0);
        checkOutput("valid_after_reset", {31'd0, out_valid}, 32'd0);
        idle(1);
        expectResult(32'h00010000, 1'b0);
        applyStimulus(38'sd65536, 7'd1, 32'sd0, 1'b0, 1'b1, 1'b1);
        idle(4);

        checkOutput("pending_results", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
